branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- N-lane branch/jump resolution stage for LoongArch32 BEQ/BNE/BLT/BGE/BLTU/BGEU/B/BL/JIRL.
- Sits after register read. Computes the actual direction and target, compares them with the front-end prediction, and produces a registered redirect plus link writeback.
- One pipeline register with valid/ready handshake. Handles in-bundle kill of lanes younger than a mispredicting lane.

Parameters:
- LANES, 2, number of instruction lanes per bundle (1..4); lane 0 is oldest.
- PC_W, 32, PC/data width.
- RESET_PC_INC, 4, PC increment for fall-through and link value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  LANES  per-lane valid
- in_ready  out  1  stage can accept a bundle
- in_pc  in  LANES*PC_W  lane PCs, lane i at [i*PC_W +: PC_W]
- in_inst  in  LANES*32  raw instruction words
- in_rj_data  in  LANES*PC_W  rj operand value
- in_rd_data  in  LANES*PC_W  rd operand value (second compare operand)
- in_pred_taken  in  LANES  predicted direction
- in_pred_target  in  LANES*PC_W  predicted target
- flush  in  1  pipeline flush from commit
- out_ready  in  1  downstream accepts
- out_valid  out  LANES  registered lane valid, killed lanes cleared
- out_is_branch  out  LANES  lane held a recognised branch/jump
- out_taken  out  LANES  resolved direction
- wb_en  out  LANES  link write enable (BL, JIRL with rd!=0)
- wb_addr  out  LANES*5  link destination (BL: 1; JIRL: rd)
- wb_data  out  LANES*PC_W  pc+4
- redirect_valid  out  1  mispredict redirect pulse
- redirect_pc  out  PC_W  correct next PC
- redirect_lane  out  $clog2(LANES)+1  index of mispredicting lane

Behaviour:
- clk, rst: one clock; reset is synchronous and active-high.
- Reset: all outputs 0 and output register empty; redirect_pc=0.
- Handshake: in_ready = !any(out_valid) || out_ready. A bundle is accepted on posedge when any(in_valid) && in_ready. Latency is 1 cycle. If the output is not taken, the register holds and all outputs stay stable.
- Decode, opcode inst[31:26]:
  - JIRL 010011
  - B 010100
  - BL 010101
  - BEQ 010110
  - BNE 010111
  - BLT 011000
  - BGE 011001
  - BLTU 011010
  - BGEU 011011
  - Other opcodes: out_is_branch=0, taken=0, no wb, never mispredict.
- Targets:
  - offs16 = sext(inst[25:10])<<2.
  - offs26 = sext({inst[9:0],inst[25:10]})<<2.
  - Conditional branches: pc+offs16.
  - B/BL: pc+offs26.
  - JIRL: rj_data+offs16.
  - Wrap modulo 2^PC_W.
- Compares: signed for BLT/BGE, unsigned for BLTU/BGEU; operands are rj_data vs rd_data.
- Mispredict on valid lane i:
  - Actual taken != pred_taken, or
  - Both taken and target != pred_target.
- Oldest (lowest index) mispredicting lane m wins:
  - redirect_valid=1.
  - redirect_pc = taken ? target : pc+4.
  - redirect_lane=m.
  - Lanes >m have out_valid and wb_en forced 0.
- redirect_valid is asserted only while the output register holds the bundle, and only for its first cycle (it does not repeat during stall).
- flush: clears the output register next edge and blocks acceptance in the same cycle. flush wins over simultaneous accept. If flush and rst occur together, rst wins.
- Lanes with in_valid=0 produce nothing, even if younger valid lanes exist (holes allowed).

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- When defined, adds outputs perf_branch_cnt[31:0] and perf_mispred_cnt[31:0].
- Both increment once per accepted-and-retired (out_valid && out_ready, non-killed) branch lane and per redirect respectively, with multi-lane add per cycle.
- Saturating at 32'hFFFF_FFFF; reset to 0.
- When absent, the ports and logic do not exist.

Decomposition:
- Shared package/defines: opcode constants (BEQ_OPCODE … JIRL_OPCODE), BR_KIND enum (NONE, COND, B, BL, JIRL), link register constant 5'd1.
- One sub-module, bru_lane_eval: combinational per-lane decode/compare/target/mispredict, instantiated LANES times.

Test Plan:
- LANES=2, lane0 BEQ pc=0x1000 offs16=4, rj=rd=5, pred_taken=1, target 0x1010 -> next cycle out_taken[0]=1, redirect_valid=0.
- Lane0 BNE rj=rd, pred_taken=1 -> redirect_valid=1, redirect_pc=0x1004, lane1 out_valid=0.
- Lane1 BL pc=0x2004 offs26=-1, pred target 0x2000 correct -> wb_en[1]=1, wb_addr=1, wb_data=0x2008, no redirect.
- BLT rj=0xFFFF_FFFF vs rd=1 taken; BLTU same operands not taken -> matches signed/unsigned rules.
- out_ready=0 for 3 cycles after mispredict -> redirect_valid high exactly 1 cycle, outputs held, in_ready=0.
- flush with in_valid asserted -> out_valid=0 next cycle, bundle dropped; JIRL rj=0x8000_0001 offs16=0 -> target 0x8000_0001 unaligned, passed as-is.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared opcodes, branch kinds and link register for the branch resolve unit.
// Optional perf counters in the top are enabled by BRU_PERF_CNT_EN.
package branch_resolve_unit_pkg;

  localparam logic [5:0] JIRL_OPCODE = 6'b010011;
  localparam logic [5:0] B_OPCODE    = 6'b010100;
  localparam logic [5:0] BL_OPCODE   = 6'b010101;
  localparam logic [5:0] BEQ_OPCODE  = 6'b010110;
  localparam logic [5:0] BNE_OPCODE  = 6'b010111;
  localparam logic [5:0] BLT_OPCODE  = 6'b011000;
  localparam logic [5:0] BGE_OPCODE  = 6'b011001;
  localparam logic [5:0] BLTU_OPCODE = 6'b011010;
  localparam logic [5:0] BGEU_OPCODE = 6'b011011;

  localparam logic [4:0] LINK_REG = 5'd1;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_COND,
    BR_B,
    BR_BL,
    BR_JIRL
  } br_kind_e;

  function automatic br_kind_e decode_kind(input logic [5:0] op);
    br_kind_e k;
    k = BR_NONE;
    unique case (1'b1)
      op == JIRL_OPCODE: k = BR_JIRL;
      op == B_OPCODE:    k = BR_B;
      op == BL_OPCODE:   k = BR_BL;
      (op >= BEQ_OPCODE) && (op <= BGEU_OPCODE):
        k = BR_COND;
      default: k = BR_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/bru_lane_eval.sv
// Per-lane combinational decode, compare, target and mispredict check.
// Part of branch_resolve_unit (optional BRU_PERF_CNT_EN lives in the top).
module bru_lane_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int PC_INC = 4
) (
  input  logic            valid,
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] rj_data,
  input  logic [PC_W-1:0] rd_data,
  input  logic            pred_taken,
  input  logic [PC_W-1:0] pred_target,
  output logic            is_branch,
  output logic            taken,
  output logic            mispred,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [PC_W-1:0] link,
  output logic [PC_W-1:0] next_pc
);

  br_kind_e        kind;
  logic [PC_W-1:0] offs16;
  logic [PC_W-1:0] offs26;
  logic [PC_W-1:0] target;
  logic            eq;
  logic            lts;
  logic            ltu;
  logic            cond;

  assign kind = decode_kind(inst[31:26]);

  assign offs16 = {{(PC_W-18){inst[25]}},
                   inst[25:10], 2'b00};
  assign offs26 = {{(PC_W-28){inst[9]}},
                   inst[9:0], inst[25:10], 2'b00};

  assign eq  = rj_data == rd_data;
  assign lts = $signed(rj_data) < $signed(rd_data);
  assign ltu = rj_data < rd_data;

  always_comb begin
    cond = 1'b0;
    unique case (1'b1)
      inst[31:26] == BEQ_OPCODE:  cond = eq;
      inst[31:26] == BNE_OPCODE:  cond = !eq;
      inst[31:26] == BLT_OPCODE:  cond = lts;
      inst[31:26] == BGE_OPCODE:  cond = !lts;
      inst[31:26] == BLTU_OPCODE: cond = ltu;
      inst[31:26] == BGEU_OPCODE: cond = !ltu;
      default:                    cond = 1'b0;
    endcase
  end

  always_comb begin
    target = pc + offs16;
    unique case (1'b1)
      kind == BR_B,
      kind == BR_BL:   target = pc + offs26;
      kind == BR_JIRL: target = rj_data + offs16;
      default:         target = pc + offs16;
    endcase
  end

  assign link      = pc + PC_W'(PC_INC);
  assign is_branch = valid && (kind != BR_NONE);
  assign taken     = is_branch &&
                     ((kind == BR_COND) ? cond : 1'b1);

  // A taken lane must also agree on where it went.
  assign mispred = is_branch &&
                   ((taken != pred_taken) ||
                    (taken && (target != pred_target)));

  assign wb_en   = valid &&
                   ((kind == BR_BL) ||
                    ((kind == BR_JIRL) && (inst[4:0] != 5'd0)));
  assign wb_addr = (kind == BR_BL) ? LINK_REG : inst[4:0];
  assign next_pc = taken ? target : link;

endmodule

// File: rtl/branch_resolve_unit.sv
// N-lane branch resolution stage with registered redirect and link writeback.
// Define BRU_PERF_CNT_EN to add saturating branch/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int PC_W         = 32,
  parameter int RESET_PC_INC = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES-1:0]             in_valid,
  output logic                         in_ready,
  input  logic [LANES*PC_W-1:0]        in_pc,
  input  logic [LANES*32-1:0]          in_inst,
  input  logic [LANES*PC_W-1:0]        in_rj_data,
  input  logic [LANES*PC_W-1:0]        in_rd_data,
  input  logic [LANES-1:0]             in_pred_taken,
  input  logic [LANES*PC_W-1:0]        in_pred_target,
  input  logic                         flush,
  input  logic                         out_ready,
  output logic [LANES-1:0]             out_valid,
  output logic [LANES-1:0]             out_is_branch,
  output logic [LANES-1:0]             out_taken,
  output logic [LANES-1:0]             wb_en,
  output logic [LANES*5-1:0]           wb_addr,
  output logic [LANES*PC_W-1:0]        wb_data,
  output logic                         redirect_valid,
  output logic [PC_W-1:0]              redirect_pc,
  output logic [$clog2(LANES):0]       redirect_lane
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_branch_cnt,
  output logic [31:0]                  perf_mispred_cnt
`endif
);

  localparam int LW = $clog2(LANES) + 1;

  logic [LANES-1:0]           l_isb;
  logic [LANES-1:0]           l_taken;
  logic [LANES-1:0]           l_mis;
  logic [LANES-1:0]           l_wben;
  logic [LANES-1:0][4:0]      l_wba;
  logic [LANES-1:0][PC_W-1:0] l_link;
  logic [LANES-1:0][PC_W-1:0] l_npc;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bru_lane_eval #(
      .PC_W  (PC_W),
      .PC_INC(RESET_PC_INC)
    ) u_eval (
      .valid      (in_valid[g]),
      .pc         (in_pc[g*PC_W +: PC_W]),
      .inst       (in_inst[g*32 +: 32]),
      .rj_data    (in_rj_data[g*PC_W +: PC_W]),
      .rd_data    (in_rd_data[g*PC_W +: PC_W]),
      .pred_taken (in_pred_taken[g]),
      .pred_target(in_pred_target[g*PC_W +: PC_W]),
      .is_branch  (l_isb[g]),
      .taken      (l_taken[g]),
      .mispred    (l_mis[g]),
      .wb_en      (l_wben[g]),
      .wb_addr    (l_wba[g]),
      .link       (l_link[g]),
      .next_pc    (l_npc[g])
    );
  end

  logic             found;
  logic [LW-1:0]    sel_lane;
  logic [PC_W-1:0]  sel_pc;
  logic [LANES-1:0] keep;
  logic             accept;

  // Lanes after the oldest mispredicting lane are on the wrong path.
  always_comb begin
    found    = 1'b0;
    sel_lane = '0;
    sel_pc   = '0;
    keep     = '1;
    for (int i = 0; i < LANES; i++) begin
      keep[i] = !found;
      if (l_mis[i] && !found) begin
        found    = 1'b1;
        sel_lane = LW'(i);
        sel_pc   = l_npc[i];
      end
    end
  end

  assign in_ready = !(|out_valid) || out_ready;
  assign accept   = (|in_valid) && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= '0;
      out_is_branch  <= '0;
      out_taken      <= '0;
      wb_en          <= '0;
      wb_addr        <= '0;
      wb_data        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      redirect_lane  <= '0;
    end else if (flush) begin
      out_valid      <= '0;
      out_is_branch  <= '0;
      out_taken      <= '0;
      wb_en          <= '0;
      redirect_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= in_valid & keep;
      out_is_branch  <= l_isb;
      out_taken      <= l_taken;
      wb_en          <= l_wben & keep;
      wb_addr        <= l_wba;
      wb_data        <= l_link;
      redirect_valid <= found;
      redirect_pc    <= sel_pc;
      redirect_lane  <= sel_lane;
    end else if (in_ready) begin
      out_valid      <= '0;
      out_is_branch  <= '0;
      out_taken      <= '0;
      wb_en          <= '0;
      redirect_valid <= 1'b0;
    end else begin
      // Stalled: hold the bundle but fire the redirect only once.
      redirect_valid <= 1'b0;
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [32:0] br_sum;

  assign br_sum = {1'b0, perf_branch_cnt} +
                  33'($countones(out_valid & out_is_branch &
                                 {LANES{out_ready}}));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branch_cnt  <= '0;
      perf_mispred_cnt <= '0;
    end else begin
      perf_branch_cnt <= br_sum[32] ? '1 : br_sum[31:0];
      if (redirect_valid && (perf_mispred_cnt != '1))
        perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus
// randomized bundles checked against a behavioural model.
module tb_branch_resolve_unit;

  localparam int LANES = 2;
  localparam int PC_W  = 32;
  localparam int LW    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [LANES-1:0]      in_valid;
  logic                  in_ready;
  logic [LANES*32-1:0]   in_pc;
  logic [LANES*32-1:0]   in_inst;
  logic [LANES*32-1:0]   in_rj_data;
  logic [LANES*32-1:0]   in_rd_data;
  logic [LANES-1:0]      in_pred_taken;
  logic [LANES*32-1:0]   in_pred_target;
  logic                  flush;
  logic                  out_ready;
  logic [LANES-1:0]      out_valid;
  logic [LANES-1:0]      out_is_branch;
  logic [LANES-1:0]      out_taken;
  logic [LANES-1:0]      wb_en;
  logic [LANES*5-1:0]    wb_addr;
  logic [LANES*32-1:0]   wb_data;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic [LW-1:0]         redirect_lane;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]           perf_branch_cnt;
  logic [31:0]           perf_mispred_cnt;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .LANES(LANES),
    .PC_W(PC_W),
    .RESET_PC_INC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_inst(in_inst),
    .in_rj_data(in_rj_data),
    .in_rd_data(in_rd_data),
    .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target),
    .flush(flush),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_is_branch(out_is_branch),
    .out_taken(out_taken),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_lane(redirect_lane)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branch_cnt(perf_branch_cnt),
    .perf_mispred_cnt(perf_mispred_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected contents of the output register.
  logic [LANES-1:0] m_valid;
  logic [LANES-1:0] m_isb;
  logic [LANES-1:0] m_taken;
  logic [LANES-1:0] m_wben;
  logic [4:0]       m_wba[LANES];
  logic [31:0]      m_wbd[LANES];
  logic             m_rv;
  logic [31:0]      m_rpc;
  logic [LW-1:0]    m_rl;

  function automatic void ref_lane(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] rj,
    input  logic [31:0] rd,
    output logic        isb,
    output logic        tk,
    output logic        wbe,
    output logic [4:0]  wba,
    output logic [31:0] tgt,
    output logic [31:0] nxt
  );
    logic [15:0] i16;
    logic [25:0] i26;
    int o16;
    int o26;
    i16 = inst[25:10];
    i26 = {inst[9:0], inst[25:10]};
    o16 = int'($signed(i16)) * 4;
    o26 = int'($signed(i26)) * 4;
    isb = 1'b1;
    tk  = 1'b0;
    wbe = 1'b0;
    wba = 5'd0;
    tgt = pc + o16;
    case (inst[31:26])
      6'h16: tk = (rj == rd);
      6'h17: tk = (rj != rd);
      6'h18: tk = ($signed(rj) < $signed(rd));
      6'h19: tk = ($signed(rj) >= $signed(rd));
      6'h1A: tk = (rj < rd);
      6'h1B: tk = (rj >= rd);
      6'h14: begin tk = 1'b1; tgt = pc + o26; end
      6'h15: begin
        tk = 1'b1; tgt = pc + o26; wbe = 1'b1; wba = 5'd1;
      end
      6'h13: begin
        tk = 1'b1; tgt = rj + o16;
        wba = inst[4:0]; wbe = (inst[4:0] != 5'd0);
      end
      default: isb = 1'b0;
    endcase
    nxt = tk ? tgt : pc + 32'd4;
  endfunction

  function automatic logic [31:0] enc16(
    input logic [5:0] op, input int w,
    input logic [4:0] rj, input logic [4:0] rd);
    logic [15:0] imm;
    imm = 16'(w);
    return {op, imm, rj, rd};
  endfunction

  function automatic logic [31:0] enc26(
    input logic [5:0] op, input int w);
    logic [25:0] imm;
    imm = 26'(w);
    return {op, imm[15:0], imm[25:16]};
  endfunction

  task automatic set_lane(
    input int i, input logic v,
    input logic [31:0] pc, input logic [31:0] inst,
    input logic [31:0] rj, input logic [31:0] rd,
    input logic pt, input logic [31:0] ptg);
    in_valid[i]            = v;
    in_pc[i*32 +: 32]      = pc;
    in_inst[i*32 +: 32]    = inst;
    in_rj_data[i*32 +: 32] = rj;
    in_rd_data[i*32 +: 32] = rd;
    in_pred_taken[i]       = pt;
    in_pred_target[i*32 +: 32] = ptg;
  endtask

  task automatic clear_inputs();
    in_valid       = '0;
    in_pc          = '0;
    in_inst        = '0;
    in_rj_data     = '0;
    in_rd_data     = '0;
    in_pred_taken  = '0;
    in_pred_target = '0;
    flush          = 1'b0;
    out_ready      = 1'b1;
  endtask

  task automatic model_clear();
    m_valid = '0;
    m_isb   = '0;
    m_taken = '0;
    m_wben  = '0;
    m_rv    = 1'b0;
  endtask

  // Advance one clock and update the model from the sampled inputs.
  task automatic tick();
    logic rdy;
    logic found;
    logic isb, tk, wbe, mis;
    logic [4:0]  wba;
    logic [31:0] tgt, nxt;
    @(posedge clk);
    rdy = !(|m_valid) || out_ready;
    if (rst) begin
      model_clear();
      m_rpc = '0;
      m_rl  = '0;
      for (int i = 0; i < LANES; i++) begin
        m_wba[i] = '0;
        m_wbd[i] = '0;
      end
    end else if (flush) begin
      model_clear();
    end else if ((|in_valid) && rdy) begin
      found = 1'b0;
      m_rpc = '0;
      m_rl  = '0;
      for (int i = 0; i < LANES; i++) begin
        ref_lane(in_pc[i*32 +: 32], in_inst[i*32 +: 32],
                 in_rj_data[i*32 +: 32], in_rd_data[i*32 +: 32],
                 isb, tk, wbe, wba, tgt, nxt);
        isb = isb && in_valid[i];
        tk  = tk && isb;
        mis = isb && ((tk != in_pred_taken[i]) ||
              (tk && (tgt != in_pred_target[i*32 +: 32])));
        m_isb[i]   = isb;
        m_taken[i] = tk;
        m_valid[i] = in_valid[i] && !found;
        m_wben[i]  = wbe && in_valid[i] && !found;
        m_wba[i]   = wba;
        m_wbd[i]   = in_pc[i*32 +: 32] + 32'd4;
        if (mis && !found) begin
          found = 1'b1;
          m_rpc = nxt;
          m_rl  = LW'(i);
        end
      end
      m_rv = found;
    end else if (rdy) begin
      model_clear();
    end else begin
      m_rv = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_out_valid got %b want 00", out_valid);
    end
    n_cmp++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_redirect got %b/%h want 0/0",
               redirect_valid, redirect_pc);
    end
    n_cmp++;
    if (wb_en !== 2'b00 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_wb_ready got %b/%b want 00/1",
               wb_en, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_beq_correct();
    clear_inputs();
    set_lane(0, 1, 32'h1000, enc16(6'h16, 4, 5'd1, 5'd2),
             32'd5, 32'd5, 1, 32'h1010);
    tick();
    n_cmp++;
    if (out_valid !== 2'b01 || out_taken[0] !== 1'b1 ||
        out_is_branch[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL beq_taken got v=%b t=%b b=%b want 01/1/1",
               out_valid, out_taken, out_is_branch);
    end
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL beq_no_redirect got %b want 0", redirect_valid);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_mispredict_stall();
    clear_inputs();
    out_ready = 1'b0;
    set_lane(0, 1, 32'h1000, enc16(6'h17, 16, 5'd1, 5'd2),
             32'd7, 32'd7, 1, 32'h1040);
    set_lane(1, 1, 32'h1004, enc26(6'h15, 8),
             32'd0, 32'd0, 1, 32'h1024);
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1004 ||
        redirect_lane !== 2'd0) begin
      n_bad++;
      $display("FAIL bne_redirect got %b/%h/%0d want 1/1004/0",
               redirect_valid, redirect_pc, redirect_lane);
    end
    n_cmp++;
    if (out_valid !== 2'b01 || wb_en !== 2'b00) begin
      n_bad++;
      $display("FAIL bne_kill got v=%b wb=%b want 01/00",
               out_valid, wb_en);
    end
    set_lane(0, 1, 32'h3000, 32'h0, 32'd0, 32'd0, 0, 32'd0);
    in_valid[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (redirect_valid !== 1'b0 || out_valid !== 2'b01 ||
          redirect_pc !== 32'h1004 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold got rv=%b v=%b pc=%h rdy=%b",
                 redirect_valid, out_valid, redirect_pc, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 2'b01 || out_is_branch !== 2'b00 ||
        redirect_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL after_stall got v=%b b=%b rv=%b want 01/00/0",
               out_valid, out_is_branch, redirect_valid);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_bl_link();
    clear_inputs();
    set_lane(0, 1, 32'h2000, 32'h0, 32'd0, 32'd0, 0, 32'd0);
    set_lane(1, 1, 32'h2004, enc26(6'h15, -1),
             32'd0, 32'd0, 1, 32'h2000);
    tick();
    n_cmp++;
    if (wb_en !== 2'b10 || wb_addr[9:5] !== 5'd1 ||
        wb_data[63:32] !== 32'h2008) begin
      n_bad++;
      $display("FAIL bl_link got en=%b a=%0d d=%h want 10/1/2008",
               wb_en, wb_addr[9:5], wb_data[63:32]);
    end
    n_cmp++;
    if (redirect_valid !== 1'b0 || out_taken !== 2'b10) begin
      n_bad++;
      $display("FAIL bl_dir got rv=%b t=%b want 0/10",
               redirect_valid, out_taken);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_signed_unsigned();
    clear_inputs();
    set_lane(0, 1, 32'h4000, enc16(6'h18, 8, 5'd1, 5'd2),
             32'hFFFF_FFFF, 32'd1, 1, 32'h4020);
    set_lane(1, 1, 32'h4004, enc16(6'h1A, 8, 5'd1, 5'd2),
             32'hFFFF_FFFF, 32'd1, 0, 32'd0);
    tick();
    n_cmp++;
    if (out_taken !== 2'b01 || redirect_valid !== 1'b0 ||
        out_valid !== 2'b11) begin
      n_bad++;
      $display("FAIL blt_bltu got t=%b rv=%b v=%b want 01/0/11",
               out_taken, redirect_valid, out_valid);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush_jirl();
    clear_inputs();
    set_lane(0, 1, 32'h5000, enc16(6'h13, 0, 5'd3, 5'd5),
             32'h8000_0001, 32'd0, 0, 32'd0);
    flush = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 2'b00 || redirect_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_drop got v=%b rv=%b want 00/0",
               out_valid, redirect_valid);
    end
    flush = 1'b0;
    out_ready = 1'b0;
    tick();
    n_cmp++;
    if (redirect_valid !== 1'b1 ||
        redirect_pc !== 32'h8000_0001) begin
      n_bad++;
      $display("FAIL jirl_target got %b/%h want 1/80000001",
               redirect_valid, redirect_pc);
    end
    n_cmp++;
    if (wb_en !== 2'b01 || wb_addr[4:0] !== 5'd5 ||
        wb_data[31:0] !== 32'h5004) begin
      n_bad++;
      $display("FAIL jirl_link got en=%b a=%0d d=%h want 01/5/5004",
               wb_en, wb_addr[4:0], wb_data[31:0]);
    end
    in_valid = '0;
    flush = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 2'b00 || wb_en !== 2'b00) begin
      n_bad++;
      $display("FAIL flush_full got v=%b wb=%b want 00/00",
               out_valid, wb_en);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [5:0]  ops[10];
    logic [31:0] vals[5];
    logic [31:0] pc, inst, rj, rd, r, tgt, nxt;
    logic        isb, tk, wbe;
    logic [4:0]  wba;
    ops  = '{6'h13, 6'h14, 6'h15, 6'h16, 6'h17,
             6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00};
    vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7};
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < LANES; i++) begin
        r    = $urandom();
        inst = {ops[$urandom_range(0, 9)], r[25:0]};
        if ($urandom_range(0, 9) == 0) inst = $urandom();
        pc = {$urandom_range(0, 65535), 2'b00};
        rj = vals[$urandom_range(0, 4)];
        rd = vals[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) rj = $urandom();
        ref_lane(pc, inst, rj, rd, isb, tk, wbe, wba, tgt, nxt);
        if ($urandom_range(0, 1) == 1) tgt = tgt ^ 32'h10;
        set_lane(i, 1'($urandom_range(0, 1)), pc, inst, rj, rd,
                 ($urandom_range(0, 3) == 0) ? !tk : tk, tgt);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
      n_cmp++;
      if (out_valid !== m_valid || out_is_branch !== m_isb ||
          out_taken !== m_taken || wb_en !== m_wben) begin
        n_bad++;
        $display("FAIL rnd_lanes c=%0d got %b%b%b%b want %b%b%b%b",
                 c, out_valid, out_is_branch, out_taken, wb_en,
                 m_valid, m_isb, m_taken, m_wben);
      end
      n_cmp++;
      if (redirect_valid !== m_rv ||
          in_ready !== (!(|m_valid) || out_ready)) begin
        n_bad++;
        $display("FAIL rnd_ctl c=%0d got rv=%b rdy=%b want rv=%b",
                 c, redirect_valid, in_ready, m_rv);
      end
      if (m_rv) begin
        n_cmp++;
        if (redirect_pc !== m_rpc || redirect_lane !== m_rl) begin
          n_bad++;
          $display("FAIL rnd_redirect c=%0d got %h/%0d want %h/%0d",
                   c, redirect_pc, redirect_lane, m_rpc, m_rl);
        end
      end
      for (int i = 0; i < LANES; i++) begin
        if (m_wben[i]) begin
          n_cmp++;
          if (wb_addr[i*5 +: 5] !== m_wba[i] ||
              wb_data[i*32 +: 32] !== m_wbd[i]) begin
            n_bad++;
            $display("FAIL rnd_wb c=%0d lane=%0d got %0d/%h want %0d/%h",
                     c, i, wb_addr[i*5 +: 5], wb_data[i*32 +: 32],
                     m_wba[i], m_wbd[i]);
          end
        end
      end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_beq_correct();
    test_mispredict_stall();
    test_bl_link();
    test_signed_unsigned();
    test_flush_jirl();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
